// File: rtl/cpu_types_pkg.sv
// Shared datapath types used across the CPU memory-side blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types and defaults for the instruction/data RAM arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACC, RESP} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
  localparam int STARVE_MAX_DEFAULT = 8;
endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter; sat flags that the waiting port has waited MAX cycles.
module starve_counter #(
  parameter int MAX = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Count waiting cycles, holding at MAX; a clear always beats an increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt >= W'(MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data memory ports.
//
// state | meaning
// IDLE  | no access in flight; requests sampled and a grant is chosen
// ACC   | RAM strobes driven from latched request until ramrdy or abort
// RESP  | one-cycle hit pulse for the granted port; strobes low
module mem_arbiter
  import mem_arbiter_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramrdy
);
  arb_state_t state;
  arb_gnt_t   gnt;
  logic       wr_q;
  word_t      addr_q;
  word_t      store_q;

  logic d_req;
  logic gnt_req;
  logic take_d;
  logic grant_i;
  logic starve_inc;
  logic starve_clr;
  logic starve_sat;

  assign d_req   = dREN | dWEN;
  assign gnt_req = (gnt == GNT_D) ? d_req : iREN;
  // Data wins unless the fetch port has starved; with no fetch pending data always wins.
  assign take_d  = d_req && (!starve_sat || !iREN);
  assign grant_i = (state == IDLE) && iREN && !take_d;

  // Fetch is only "being served" while its own access is in ACC/RESP.
  assign starve_inc = iREN && ((gnt != GNT_I) || !((state == ACC) || (state == RESP)));
  assign starve_clr = !iREN || grant_i;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .CLK (CLK),
    .RST (RST),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Grant, access and response sequencing with registered strobes, hits and load data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      gnt     <= GNT_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      iload   <= '0;
      dload   <= '0;
      ihit    <= 1'b0;
      dhit    <= 1'b0;
      ramREN  <= 1'b0;
      ramWEN  <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (take_d) begin
            gnt     <= GNT_D;
            addr_q  <= daddr;
            store_q <= dstore;
            wr_q    <= dWEN;
            ramREN  <= !dWEN;
            ramWEN  <= dWEN;
            state   <= ACC;
          end else if (iREN) begin
            gnt     <= GNT_I;
            addr_q  <= iaddr;
            wr_q    <= 1'b0;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            state   <= ACC;
          end
        end
        ACC: begin
          // A dropped request abandons the access even if the RAM answers in the same cycle.
          if (!gnt_req) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= IDLE;
          end else if (ramrdy) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= RESP;
            if (gnt == GNT_I) begin
              iload <= ramload;
              ihit  <= 1'b1;
            end else begin
              dhit <= 1'b1;
              if (!wr_q) begin
                dload <= ramload;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;
  localparam int SMAX = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramrdy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: phase 0 = free, 1 = RAM busy, 2 = answering
  int          m_phase;
  bit          m_to_d;
  bit          m_wr;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  bit          m_ihit, m_dhit;
  int          m_wait;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .ihit     (ihit),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramrdy   (ramrdy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance the model by one clock using the inputs that the DUT is about to sample.
  task automatic model_step();
    bit dq;
    bit req;
    bit waiting;
    bit i_granted;
    dq        = dREN | dWEN;
    i_granted = 1'b0;
    if (RST) begin
      m_phase = 0; m_to_d = 0; m_wr = 0; m_addr = 0; m_store = 0;
      m_iload = 0; m_dload = 0; m_ihit = 0; m_dhit = 0; m_wait = 0;
      return;
    end
    waiting = iREN && (m_to_d || m_phase == 0);
    m_ihit  = 0;
    m_dhit  = 0;
    if (m_phase == 0) begin
      if (dq && (m_wait < SMAX || !iREN)) begin
        m_to_d = 1; m_addr = daddr; m_store = dstore; m_wr = dWEN; m_phase = 1;
      end else if (iREN) begin
        m_to_d = 0; m_addr = iaddr; m_wr = 0; m_phase = 1; i_granted = 1;
      end
    end else if (m_phase == 1) begin
      req = m_to_d ? dq : iREN;
      if (!req) m_phase = 0;
      else if (ramrdy) begin
        m_phase = 2;
        if (m_to_d) begin
          m_dhit = 1;
          if (!m_wr) m_dload = ramload;
        end else begin
          m_ihit  = 1;
          m_iload = ramload;
        end
      end
    end else begin
      m_phase = 0;
    end
    if (!iREN || i_granted) m_wait = 0;
    else if (waiting) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
  endtask

  task automatic check_outputs();
    check("ramREN",   32'(ramREN),   32'(m_phase == 1 && !m_wr));
    check("ramWEN",   32'(ramWEN),   32'(m_phase == 1 && m_wr));
    check("ramaddr",  ramaddr,       m_addr);
    check("ramstore", ramstore,      m_store);
    check("ihit",     32'(ihit),     32'(m_ihit));
    check("dhit",     32'(dhit),     32'(m_dhit));
    check("iload",    iload,         m_iload);
    check("dload",    dload,         m_dload);
    check("one_hit",  32'(ihit && dhit), 32'(0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  initial begin
    int t_i, t_d, t_g;
    bit abort;
    RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ramrdy = 0;

    // reset state
    do_reset();
    check("rst_ihit", 32'(ihit), 32'(0));
    check("rst_ramaddr", ramaddr, 32'h0);

    // single instruction read, zero wait
    iREN = 1; iaddr = 32'h40; ramrdy = 1; ramload = 32'h8C010004;
    cycle();
    check("rd_ramREN", 32'(ramREN), 32'(1));
    check("rd_ramaddr", ramaddr, 32'h40);
    cycle();
    check("rd_ihit", 32'(ihit), 32'(1));
    check("rd_iload", iload, 32'h8C010004);
    check("rd_dhit", 32'(dhit), 32'(0));
    iREN = 0; ramrdy = 0;
    cycle();

    // data write with three wait states
    dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramload = 32'h55AA55AA;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("wr_ramWEN", 32'(ramWEN), 32'(1));
      check("wr_ramstore", ramstore, 32'hDEADBEEF);
      check("wr_dhit_early", 32'(dhit), 32'(0));
    end
    ramrdy = 1;
    cycle();
    check("wr_dhit", 32'(dhit), 32'(1));
    check("wr_dload", dload, 32'h0);
    check("wr_ramWEN_off", 32'(ramWEN), 32'(0));
    dWEN = 0; ramrdy = 0;
    cycle();

    // data read then an aborted data read
    dREN = 1; daddr = 32'h300; ramrdy = 1; ramload = 32'hCAFEF00D;
    cycle(); cycle();
    check("drd_dload", dload, 32'hCAFEF00D);
    dREN = 0; ramrdy = 0;
    cycle();
    dREN = 1; daddr = 32'h304; ramload = 32'h11111111;
    cycle();
    check("ab_ramREN", 32'(ramREN), 32'(1));
    dREN = 0;
    cycle();
    check("ab_dhit", 32'(dhit), 32'(0));
    check("ab_ramREN_off", 32'(ramREN), 32'(0));
    cycle();
    check("ab_dhit2", 32'(dhit), 32'(0));
    check("ab_dload", dload, 32'hCAFEF00D);

    // contention from reset release
    RST = 1; iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h180; ramrdy = 1;
    cycle();
    RST = 0;
    t_i = -1; t_d = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (dhit && t_d < 0) t_d = c;
      if (ihit && t_i < 0) t_i = c;
      if (m_dhit) dREN = 0;
      if (m_ihit) iREN = 0;
    end
    check("cont_dhit_cycle", 32'(t_d), 32'(2));
    check("cont_ihit_cycle", 32'(t_i), 32'(5));

    // starvation: data request always pending, fetch must get in after SMAX cycles
    iREN = 0; dREN = 0; ramrdy = 0;
    do_reset();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h88; ramrdy = 1; ramload = 32'h0BADCAFE;
    t_g = -1;
    for (int c = 1; c <= 14; c++) begin
      cycle();
      if (ramREN && ramaddr == 32'h44 && t_g < 0) t_g = c;
      if (c == 13) check("starve_next_d", ramaddr, 32'h88);
    end
    check("starve_i_grant", 32'(t_g), 32'(10));

    // reset in the middle of an access
    iREN = 0; dREN = 0; ramrdy = 0;
    cycle(); cycle();
    iREN = 1; iaddr = 32'h500;
    cycle();
    check("mid_acc", 32'(ramREN), 32'(1));
    RST = 1;
    cycle();
    RST = 0;
    check("mid_rst_ramREN", 32'(ramREN), 32'(0));
    check("mid_rst_iload", iload, 32'h0);
    check("mid_rst_ramaddr", ramaddr, 32'h0);
    ramrdy = 1; ramload = 32'h77665544;
    cycle();
    check("post_rst_addr", ramaddr, 32'h500);
    cycle();
    check("post_rst_ihit", 32'(ihit), 32'(1));
    check("post_rst_iload", iload, 32'h77665544);
    iREN = 0; ramrdy = 0;
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      abort = 1'b0;
      if (m_phase == 1 && $urandom_range(0, 19) == 0) begin
        abort = 1'b1;
        if (m_to_d) begin dREN = 0; dWEN = 0; end
        else iREN = 0;
      end
      if (!abort) begin
        if (m_ihit || !iREN) begin
          iREN  = ($urandom_range(0, 2) != 0);
          iaddr = $urandom;
        end
        if (m_dhit || !(dREN || dWEN)) begin
          case ($urandom_range(0, 3))
            0: begin dREN = 0; dWEN = 0; end
            1: begin dREN = 1; dWEN = 0; end
            2: begin dREN = 0; dWEN = 1; end
            default: begin dREN = 1; dWEN = 1; end
          endcase
          daddr  = $urandom;
          dstore = $urandom;
        end
      end
      ramrdy  = abort ? 1'b0 : ($urandom_range(0, 2) == 0);
      ramload = $urandom;
      RST     = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single-ported main RAM between the datapath's instruction-fetch port and its data-memory port. Each access is granted, held until the RAM signals ready, and answered with a one-cycle hit pulse and registered load data. Data requests have priority, since the memory stage stalls the whole pipeline. A starvation counter forces an instruction grant after a bounded wait. The block sits between the datapath/cache ports and the RAM model.

## Interface
- STARVE_MAX, 8, consecutive non-granted cycles with iREN high before the instruction port takes priority (≥1)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset; synchronous and active-high
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction word address
- ihit  out  1  one-cycle pulse: iload valid
- iload  out  32  registered instruction word
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data address
- dstore  in  32  write data
- dhit  out  1  one-cycle pulse: data access complete
- dload  out  32  registered read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid with ramrdy
- ramrdy  in  1  RAM access complete this cycle

## Operation
- FSM states: IDLE, ACC, RESP. Grant register gnt ∈ {GNT_I, GNT_D}. Write flag wr_q.
- IDLE: if the data request (dREN|dWEN) is pending and starve < STARVE_MAX, grant D. Else if iREN, grant I. Else if the data request is pending, grant D. Else stay.
- On grant, latch addr_q (iaddr/daddr), store_q (dstore, D only) and wr_q (dWEN, D only). Go to ACC.
- dREN and dWEN both high: treated as a write. dload is unchanged.
- ACC: ramaddr=addr_q, ramstore=store_q, ramREN=!wr_q, ramWEN=wr_q.
  - ramrdy=1: capture ramload into iload/dload (reads only) and go to RESP.
  - The granted request drops before ramrdy: abort to IDLE with no hit and no capture.
- RESP: the granted port's hit=1 for exactly this cycle. RAM strobes are 0. Next state is IDLE. The requester may drop or change its request in this cycle; it is sampled only in IDLE.
- Starvation counter starve: saturating counter of width $clog2(STARVE_MAX+1).
  - Increments each cycle iREN=1 and gnt≠GNT_I or state≠ACC/RESP.
  - Cleared on I grant and when iREN=0.
- Outside ACC: ramREN=ramWEN=0; ramaddr and ramstore hold the latched values.

## Timing
- RST (sampled at an edge) forces the following, overriding all other activity including mid-ACC: state=IDLE, gnt=GNT_I, wr_q=0, addr_q=0, store_q=0, starve=0, iload=0, dload=0, ihit=0, dhit=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Minimum latency, with the request first seen in IDLE at cycle 0:
  - ACC in cycle 1.
  - If ramrdy=1 in cycle 1, the hit pulse and valid load data come in cycle 2.
  - Back-to-back accesses: the next grant is in cycle 3, so throughput is one access per 3 cycles at zero RAM wait.
- Each ramrdy wait cycle adds exactly one cycle. ramrdy outside ACC is ignored.
- iload and dload hold their values until the next completed read of that port.
- Simultaneous I and D requests in IDLE: D wins unless starve ≥ STARVE_MAX.
- hit is never asserted for an aborted access. At most one of ihit and dhit is high in any cycle.

## Structure
- Package mem_arbiter_pkg:
  - arb_state_t enum {IDLE, ACC, RESP}
  - arb_gnt_t enum {GNT_I, GNT_D}
  - default STARVE_MAX
- word_t comes from cpu_types_pkg.
- One sub-module: starve_counter. Parameter MAX; inputs CLK, RST, inc, clr; output sat (count ≥ MAX).
- FSM, grant/latch registers and RAM drive live in mem_arbiter (roughly 150–250 lines).

## Test plan
- Single read: iREN=1, iaddr=0x40, ramrdy=1 in first ACC cycle, ramload=0x8C010004 -> ramREN=1 with ramaddr=0x40 in cycle 1; ihit=1 and iload=0x8C010004 in cycle 2; dhit stays 0.
- Write with 3 wait states: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramrdy high on the 4th ACC cycle -> ramWEN=1 for 4 cycles, ramstore=0xDEADBEEF; dhit in the following cycle; dload unchanged.
- Contention: iREN and dREN both high from reset release -> the D access completes first, then I is granted in the IDLE after D's RESP.
- Starvation, STARVE_MAX=8: iREN held high while the data request is re-asserted every IDLE -> I is granted in the first IDLE after starve reaches 8, then starve=0.
- Abort: dREN drops during ACC before ramrdy -> state returns to IDLE next cycle, no dhit, dload unchanged.
- Reset mid-ACC: RST=1 for one edge while ACC -> all outputs at reset values next cycle, no hit; a pending iREN is granted normally afterwards.
